// File: rtl/display_mux8.sv
// Eight-digit common-anode seven-segment scan driver: one anode low per dwell period.
// Optional leading-zero blanking is enabled by defining DISPLAY_MUX_LZ_BLANK_EN.
module display_mux8 #(
    parameter int DWELL = 1
) (
    input  logic        clk_1kHz,
    input  logic        rst_n,
    input  logic [31:0] digits_in,
    input  logic [7:0]  dp_in,
    input  logic [7:0]  digit_en,
    output logic [7:0]  anodes,
    output logic [6:0]  seg_out,
    output logic        dp_out,
    output logic [2:0]  current_digit
);

    // state   | meaning
    // ST_IDLE | in or just out of reset, display dark, idx held at 0
    // ST_SCAN | scanning, digit idx driven for DWELL edges, then idx advances
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

    state_t     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] dwell_cnt_q, dwell_cnt_d;
    logic       active;
    logic [7:0] lz_keep;
    logic [3:0] nibble;
    logic       visible;

    function automatic logic [6:0] hex_decode(input logic [3:0] v);
        case (v)
            4'h0: hex_decode = 7'h40;
            4'h1: hex_decode = 7'h79;
            4'h2: hex_decode = 7'h24;
            4'h3: hex_decode = 7'h30;
            4'h4: hex_decode = 7'h19;
            4'h5: hex_decode = 7'h12;
            4'h6: hex_decode = 7'h02;
            4'h7: hex_decode = 7'h78;
            4'h8: hex_decode = 7'h00;
            4'h9: hex_decode = 7'h10;
            4'hA: hex_decode = 7'h08;
            4'hB: hex_decode = 7'h03;
            4'hC: hex_decode = 7'h46;
            4'hD: hex_decode = 7'h21;
            4'hE: hex_decode = 7'h06;
            default: hex_decode = 7'h0E;
        endcase
    endfunction

    always_ff @(posedge clk_1kHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= 3'd0;
            dwell_cnt_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            dwell_cnt_q <= dwell_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        dwell_cnt_d = dwell_cnt_q;
        case (state_q)
            ST_IDLE: state_d = ST_SCAN;
            ST_SCAN: begin
                if (dwell_cnt_q == DWELL_LAST) begin
                    dwell_cnt_d = 8'd0;
                    idx_d       = idx_q + 3'd1;
                end else begin
                    dwell_cnt_d = dwell_cnt_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign active        = (state_q == ST_SCAN);
    assign current_digit = idx_q;

`ifdef DISPLAY_MUX_LZ_BLANK_EN
    // A digit survives if it or any higher digit is non-zero or carries a decimal point.
    always_comb begin
        lz_keep    = 8'h00;
        lz_keep[7] = (|digits_in[31:28]) | dp_in[7];
        for (int k = 6; k >= 0; k--) begin
            lz_keep[k] = lz_keep[k+1] | (|digits_in[4*k +: 4]) | dp_in[k];
        end
        lz_keep[0] = 1'b1;
    end
`else
    assign lz_keep = 8'hFF;
`endif

    assign nibble  = digits_in[{idx_q, 2'b00} +: 4];
    assign visible = active & digit_en[idx_q] & lz_keep[idx_q];

    always_comb begin
        anodes  = 8'hFF;
        seg_out = 7'h7F;
        dp_out  = 1'b1;
        if (visible) begin
            anodes  = ~(8'h01 << idx_q);
            seg_out = hex_decode(nibble);
            dp_out  = ~dp_in[idx_q];
        end
    end

endmodule

// File: tb/tb_display_mux8.sv
// Scoreboard bench for display_mux8: a DWELL=1 and a DWELL=3 instance share stimulus;
// expected outputs come from an edge-count model of the scan and are checked at negedge.
module tb_display_mux8;

    logic        clk_1kHz = 1'b0;
    logic        rst_n    = 1'b0;
    logic [31:0] digits_in = 32'h89ABCDEF;
    logic [7:0]  dp_in     = 8'h00;
    logic [7:0]  digit_en  = 8'hFF;

    logic [7:0] an1, an3;
    logic [6:0] seg1, seg3;
    logic       dp1, dp3;
    logic [2:0] cd1, cd3;

    display_mux8 #(.DWELL(1)) dut1 (
        .clk_1kHz(clk_1kHz), .rst_n(rst_n), .digits_in(digits_in), .dp_in(dp_in),
        .digit_en(digit_en), .anodes(an1), .seg_out(seg1), .dp_out(dp1), .current_digit(cd1)
    );

    display_mux8 #(.DWELL(3)) dut3 (
        .clk_1kHz(clk_1kHz), .rst_n(rst_n), .digits_in(digits_in), .dp_in(dp_in),
        .digit_en(digit_en), .anodes(an3), .seg_out(seg3), .dp_out(dp3), .current_digit(cd3)
    );

    always #5 clk_1kHz = ~clk_1kHz;

    typedef struct {
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
        logic [2:0] cd;
    } out_t;

    typedef struct {
        out_t d1;
        out_t d3;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   n_edges = 0;   // rising edges seen with reset released

    logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    function automatic out_t model(int n, int dwell, logic [31:0] d, logic [7:0] dp,
                                   logic [7:0] en, logic rst_ok);
        out_t o;
        int   k;
        bit   show;
        o.an = 8'hFF; o.seg = 7'h7F; o.dp = 1'b1; o.cd = 3'd0;
        if (!rst_ok || n == 0) return o;
        k    = ((n - 1) / dwell) % 8;
        o.cd = 3'(k);
        show = en[k];
`ifdef DISPLAY_MUX_LZ_BLANK_EN
        if (k >= 1 && (d >> (4 * k)) == 0 && (dp >> k) == 0) show = 0;
`endif
        if (show) begin
            o.an  = 8'hFF ^ (8'h01 << k);
            o.seg = hex_tab[(d >> (4 * k)) & 32'hF];
            o.dp  = ~dp[k];
        end
        return o;
    endfunction

    task automatic cycle(input logic [31:0] d, input logic [7:0] dp, input logic [7:0] en,
                         input logic r);
        exp_t e;
        @(posedge clk_1kHz);
        if (rst_n) n_edges++;
        #2;
        digits_in = d;
        dp_in     = dp;
        digit_en  = en;
        rst_n     = r;
        if (!r) n_edges = 0;
        e.d1 = model(n_edges, 1, d, dp, en, r);
        e.d3 = model(n_edges, 3, d, dp, en, r);
        q.push_back(e);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk_1kHz) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("anodes_dw1", int'(an1), int'(e.d1.an));
            chk("seg_dw1", int'(seg1), int'(e.d1.seg));
            chk("dp_dw1", int'(dp1), int'(e.d1.dp));
            chk("digit_dw1", int'(cd1), int'(e.d1.cd));
            chk("anodes_dw3", int'(an3), int'(e.d3.an));
            chk("seg_dw3", int'(seg3), int'(e.d3.seg));
            chk("dp_dw3", int'(dp3), int'(e.d3.dp));
            chk("digit_dw3", int'(cd3), int'(e.d3.cd));
        end
    end

    initial begin
        logic [31:0] rd;
        logic [7:0]  rdp, ren;
        logic        rr;
        int          guard;

        for (int i = 0; i < 3; i++) cycle(32'h89ABCDEF, 8'h00, 8'hFF, 1'b0);
        for (int i = 0; i < 30; i++) cycle(32'h89ABCDEF, 8'h00, 8'hFF, 1'b1);
        for (int i = 0; i < 30; i++) cycle(32'h89ABCDEF, 8'h04, 8'hFD, 1'b1);

        // Walk the DWELL=1 scan until the next edge lands on digit 5, then reset there.
        guard = 0;
        while (((n_edges - 1) % 8) != 4 && guard < 20) begin
            cycle(32'h13572468, 8'h00, 8'hFF, 1'b1);
            guard++;
        end
        chk("reach_digit5_bound", guard < 20 ? 1 : 0, 1);
        cycle(32'h13572468, 8'h00, 8'hFF, 1'b0);
        cycle(32'h13572468, 8'h00, 8'hFF, 1'b0);
        for (int i = 0; i < 12; i++) cycle(32'h13572468, 8'h00, 8'hFF, 1'b1);

        for (int i = 0; i < 26; i++) cycle(32'h00000305, 8'h00, 8'hFF, 1'b1);
        for (int i = 0; i < 26; i++) cycle(32'h00000000, 8'h00, 8'hFF, 1'b1);
        for (int i = 0; i < 26; i++) cycle(32'h00000000, 8'h20, 8'hFF, 1'b1);

        for (int i = 0; i < 300; i++) begin
            rd  = $urandom >> ($urandom_range(0, 8) * 4);
            rdp = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            ren = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom);
            rr  = ($urandom_range(0, 49) != 0);
            cycle(rd, rdp, ren, rr);
        end

        repeat (3) @(negedge clk_1kHz);
        chk("scoreboard_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/display_mux8.md
# display_mux8

Time-multiplexed driver for an 8-digit common-anode seven-segment display in the muon-lifetime readout path. It sits between the counter/BCD conversion logic and the board display pins. It scans one digit per dwell period from the 1 kHz scan clock, asserting one anode at a time. For the active digit it drives the hex-decoded segment pattern and the decimal point, and it reports the active digit index.

## Interface
- `DWELL`, default 1: scan-clock cycles each digit stays active; legal range 1..255.
- `clk_1kHz`  input  1  scan clock, rising-edge active.
- `rst_n`  input  1  reset, asynchronous and active-low.
- `digits_in`  input  32  eight 4-bit hex values; digit k is `[4k+3:4k]`; digit 0 is the rightmost.
- `dp_in`  input  8  decimal point request per digit, active-high.
- `digit_en`  input  8  per-digit enable; 0 blanks that digit.
- `anodes`  output  8  anode enables, active-low, one-cold while scanning.
- `seg_out`  output  7  segment cathodes, active-low; bit0=a … bit6=g.
- `dp_out`  output  1  decimal point cathode, active-low.
- `current_digit`  output  3  index of the digit currently selected.

## Operation
- Registers:
  - `idx` (3 bits)
  - `dwell_cnt` (8 bits)
  - `active` (1 bit)
- `current_digit` equals `idx` directly.
- Reset (`rst_n` low, asynchronous) sets `idx`=0, `dwell_cnt`=0 and `active`=0.
- First rising edge after reset release: `active` becomes 1; `idx` does not change.
- While `active`=1, each edge:
  - if `dwell_cnt`==DWELL-1, then `dwell_cnt`←0 and `idx`←`idx`+1, wrapping 7→0;
  - otherwise `dwell_cnt` increments.
- Outputs are combinational from the registers and the inputs.
- Digit k is visible when `active`=1, `idx`==k, `digit_en[k]`=1, and it is not blanked by the Configuration feature.
- When digit `idx` is visible:
  - `anodes` = ~(1<<`idx`);
  - `seg_out` = hex decode of nibble `idx`;
  - `dp_out` = ~`dp_in[idx]`.
- When digit `idx` is not visible: `anodes`=8'hFF, `seg_out`=7'h7F, `dp_out`=1.
- Hex decode, active-low g..a:
  - 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30
  - 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78
  - 8=7'h00, 9=7'h10, A=7'h08, b=7'h03
  - C=7'h46, d=7'h21, E=7'h06, F=7'h0E
- Inputs may change at any time. They are sampled combinationally, so a change shows on the active digit immediately.

## Timing
- Reset values:
  - `anodes`=8'hFF
  - `seg_out`=7'h7F
  - `dp_out`=1
  - `current_digit`=0
- Reset asserted mid-scan forces all outputs to their reset values with no clock edge.
- Latency, release to first lit digit: one edge (digit 0).
- Each digit is then lit for exactly DWELL cycles.
- Full scan period = 8×DWELL cycles; at the default, 8 ms at 1 kHz.
- No two anodes are ever low simultaneously.
- Anode transitions occur only on rising edges or on reset assertion.

## Configuration
- `DISPLAY_MUX_LZ_BLANK_EN`: leading-zero blanking.
- When defined:
  - digit k (k≥1) is blanked when nibbles k..7 are all zero;
  - digit 0 is never blanked by this rule;
  - `digit_en` still applies on top;
  - `dp_in[k]`=1 on digit k, or on any higher digit, disables blanking for digit k and all lower digits.
- When undefined, only `digit_en` blanks digits.
- Scan timing is identical either way.

## Test plan
- **Reset release, DWELL=1:**
  - during reset, `anodes`=FF and `current_digit`=0;
  - edge 1 gives `anodes`=FE;
  - edges 2..8 give FD, FB, F7, EF, DF, BF, 7F;
  - edge 9 returns to FE and `current_digit`=0.
- **Decode:**
  - `digits_in`=32'h89ABCDEF with all enabled;
  - digit 0 shows `seg_out`=0E (F), digit 3 shows 46 (C), digit 7 shows 00 (8).
- **Masking:**
  - `digit_en`=8'b11111101, `dp_in`=8'h04;
  - digit 1 gives `anodes`=FF, `seg_out`=7F;
  - digit 2 gives `dp_out`=0; all others give `dp_out`=1.
- **DWELL=3:**
  - each `current_digit` value persists exactly 3 edges;
  - the full wrap takes 24 edges.
- **Mid-scan reset:**
  - assert `rst_n` low asynchronously at `current_digit`=5;
  - outputs return to reset values at once;
  - after release, the first lit digit is 0.
- **`DISPLAY_MUX_LZ_BLANK_EN` defined:**
  - `digits_in`=32'h00000305 lights digits 0–2 only, showing 5, 0, 3;
  - `digits_in`=0 lights digit 0 only, showing 0.
